// File: rtl/glip_fifo_out_arbiter.sv
// Round-robin, burst-locked arbiter sharing the GLIP Logic->Host FIFO between PORTS requesters.
// Define GLIP_ARB_HEADER_EN to prefix every grant with a {8'hA5, port} header word.
module glip_fifo_out_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PORTS     = 4,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PORTS-1:0]       req_valid,
    input  logic [PORTS*WIDTH-1:0] req_data,
    input  logic [PORTS-1:0]       req_last,
    output logic [PORTS-1:0]       req_ready,
    output logic                   fifo_out_valid,
    output logic [WIDTH-1:0]       fifo_out_data,
    input  logic                   fifo_out_ready,
    output logic [PORTS-1:0]       grant,
    output logic                   busy
);
    localparam int unsigned SelW     = $clog2(PORTS);
    localparam logic [15:0] BeatLast = 16'(MAX_BURST - 1);

`ifdef GLIP_ARB_HEADER_EN
    typedef enum logic [1:0] {StIdle, StData, StHdr} state_e;
`else
    typedef enum logic {StIdle, StData} state_e;
`endif

    state_e           state_q, state_d;
    // sel_q also serves as the last-granted pointer for the round-robin search.
    logic [SelW-1:0]  sel_q, sel_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [15:0]      beat_q, beat_d;
    logic [SelW-1:0]  pick_idx, cand;
    logic             pick_found;
    logic             xfer, burst_end;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= int'(PORTS); k++) begin
            cand = SelW'((int'(sel_q) + k) % int'(PORTS));
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        grant_d        = grant_q;
        beat_d         = beat_q;
        req_ready      = '0;
        fifo_out_valid = 1'b0;
        fifo_out_data  = '0;
        xfer           = 1'b0;
        burst_end      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    grant_d = {{(PORTS-1){1'b0}}, 1'b1} << pick_idx;
                    beat_d  = '0;
`ifdef GLIP_ARB_HEADER_EN
                    state_d = StHdr;
`else
                    state_d = StData;
`endif
                end
            end
`ifdef GLIP_ARB_HEADER_EN
            StHdr: begin
                fifo_out_valid = 1'b1;
                fifo_out_data  = {8'hA5, (WIDTH-8)'(sel_q)};
                if (fifo_out_ready) begin
                    state_d = StData;
                end
            end
`endif
            StData: begin
                fifo_out_valid   = req_valid[sel_q];
                fifo_out_data    = req_data[sel_q*WIDTH +: WIDTH];
                req_ready[sel_q] = fifo_out_ready;
                xfer             = req_valid[sel_q] && fifo_out_ready;
                burst_end        = xfer && (req_last[sel_q] || beat_q == BeatLast);
                if (burst_end) begin
                    state_d = StIdle;
                    grant_d = '0;
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= SelW'(PORTS - 1);
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_glip_fifo_out_arbiter.sv
// Self-checking bench for glip_fifo_out_arbiter: vector table, directed corner sequences
// and a randomized run against a transaction-level round-robin model.
module tb_glip_fifo_out_arbiter;
    localparam int W  = 16;
    localparam int P  = 4;
    localparam int MB = 64;
`ifdef GLIP_ARB_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [P-1:0]   req_valid, req_last, req_ready, grant, req_ready_b, grant_b;
    logic [P*W-1:0] req_data;
    logic           fifo_out_ready, fifo_out_valid, busy, fifo_out_valid_b, busy_b;
    logic [W-1:0]   fifo_out_data, fifo_out_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    glip_fifo_out_arbiter #(.WIDTH(W), .PORTS(P), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_out_valid(fifo_out_valid),
        .fifo_out_data(fifo_out_data), .fifo_out_ready(fifo_out_ready), .grant(grant),
        .busy(busy)
    );

    glip_fifo_out_arbiter #(.WIDTH(W), .PORTS(P), .MAX_BURST(4)) dut_b4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready_b), .fifo_out_valid(fifo_out_valid_b),
        .fifo_out_data(fifo_out_data_b), .fifo_out_ready(fifo_out_ready), .grant(grant_b),
        .busy(busy_b)
    );

    typedef struct {
        logic         v;
        logic         l;
        logic [W-1:0] d;
        logic         e_valid;
        logic         e_busy;
        logic [W-1:0] e_data;
        logic [P-1:0] e_grant;
        logic [P-1:0] e_rdy;
    } vec_t;

    vec_t         tbl[$];
    int           got[$];
    int           bursts[$];
    int           n_words[P];
    int           pkt_len[P];
    int           wcnt[P];
    int           rx[P];
    int           m_owner, m_last, m_beats;
    bit           m_hdr;
    bit           all_done;
    logic [P-1:0] en_r;
    logic [P-1:0] first_grant_main;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic l, input logic [W-1:0] d,
                                input logic ev, input logic eb, input logic [W-1:0] ed,
                                input logic [P-1:0] eg, input logic [P-1:0] er);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.e_valid = ev; r.e_busy = eb;
        r.e_data = ed; r.e_grant = eg; r.e_rdy = er;
        return r;
    endfunction

    function automatic int idx_of(input logic [P-1:0] v);
        for (int i = 0; i < P; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input int last, input logic [P-1:0] v);
        for (int k = 1; k <= P; k++) if (v[(last + k) % P]) return (last + k) % P;
        return -1;
    endfunction

    function automatic logic [W-1:0] word_of(input int p, input int w);
        return W'((p << 12) | (w & 'hfff));
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        req_valid      = '0;
        req_last       = '0;
        req_data       = '0;
        fifo_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ports(input logic [P-1:0] en);
        for (int p = 0; p < P; p++) begin
            req_valid[p]       = en[p] && (wcnt[p] < n_words[p]);
            req_last[p]        = (pkt_len[p] > 0) ? ((wcnt[p] + 1) % pkt_len[p] == 0) : 1'b0;
            req_data[p*W +: W] = word_of(p, wcnt[p]);
        end
    endtask

    // Runs the port streams for a fixed number of cycles and records bursts as port*100+len.
    task automatic run_seq(input bit use_b4, input int cycles);
        int           cur_port, cur_len;
        bit           prev_busy;
        logic [P-1:0] rdy, g;
        logic         bz, vo;
        logic [W-1:0] dout;
        cur_port = -1;
        cur_len = 0;
        prev_busy = 1'b0;
        bursts.delete();
        first_grant_main = '0;
        for (int c = 0; c < cycles; c++) begin
            drive_ports('1);
            @(negedge clk);
            rdy  = use_b4 ? req_ready_b : req_ready;
            g    = use_b4 ? grant_b : grant;
            bz   = use_b4 ? busy_b : busy;
            vo   = use_b4 ? fifo_out_valid_b : fifo_out_valid;
            dout = use_b4 ? fifo_out_data_b : fifo_out_data;
            if (first_grant_main == '0) first_grant_main = grant;
            if (bz) begin
                cur_port = idx_of(g);
                for (int p = 0; p < P; p++) begin
                    if (rdy[p] && req_valid[p]) begin
                        chk("seq_valid", vo, 1'b1);
                        chk("seq_data", dout, word_of(p, wcnt[p]));
                        cur_len++;
                        wcnt[p]++;
                    end
                end
            end else if (prev_busy) begin
                bursts.push_back(cur_port * 100 + cur_len);
                cur_len = 0;
            end
            prev_busy = bz;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic model_step();
        logic [P-1:0] e_grant, e_rdy;
        logic         e_valid;
        logic [W-1:0] e_data;
        int           p;
        e_grant = '0;
        e_rdy   = '0;
        e_valid = 1'b0;
        e_data  = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            if (m_hdr) begin
                e_valid = 1'b1;
                e_data  = {8'hA5, 8'(m_owner)};
            end else begin
                e_valid        = req_valid[m_owner];
                e_data         = word_of(m_owner, rx[m_owner]);
                e_rdy[m_owner] = fifo_out_ready;
            end
        end
        chk("rnd_grant", grant, e_grant);
        chk("rnd_busy", busy, m_owner >= 0);
        chk("rnd_valid", fifo_out_valid, e_valid);
        chk("rnd_ready", req_ready, e_rdy);
        chk("rnd_data", fifo_out_data, e_data);
        if (m_owner < 0) begin
            p = rr_pick(m_last, req_valid);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_beats = 0;
                m_hdr   = HDR;
            end
        end else if (m_hdr) begin
            if (fifo_out_ready) m_hdr = 1'b0;
        end else if (req_valid[m_owner] && fifo_out_ready) begin
            rx[m_owner]++;
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) m_owner = -1;
        end
    endtask

    initial begin
        int exp_a[5];
        int exp_c[4];

        // Reset state with every requester idle.
        req_valid      = '0;
        req_last       = '0;
        req_data       = '0;
        fifo_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", fifo_out_valid, 1'b0);
        chk("rst_data", fifo_out_data, '0);
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, '0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_valid", fifo_out_valid, 1'b0);
            chk("idle_ready", req_ready, '0);
        end
        @(posedge clk);
        #1;

        // Port 2 alone: five words, last on the fifth.
        tbl.push_back(mk(1'b1, 1'b0, 16'h2001, 1'b0, 1'b0, 16'h0, 4'b0000, 4'b0000));
        if (HDR) tbl.push_back(mk(1'b1, 1'b0, 16'h2001, 1'b1, 1'b1, 16'hA502, 4'b0100, 4'b0000));
        for (int w = 1; w <= 5; w++) begin
            tbl.push_back(mk(1'b1, w == 5, W'(16'h2000 + w), 1'b1, 1'b1, W'(16'h2000 + w),
                             4'b0100, 4'b0100));
        end
        tbl.push_back(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'b0000, 4'b0000));
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid            = '0;
            req_last             = '0;
            req_data             = '0;
            req_valid[2]         = tbl[i].v;
            req_last[2]          = tbl[i].l;
            req_data[2*W +: W]   = tbl[i].d;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), fifo_out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_data", i), fifo_out_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            @(posedge clk);
            #1;
        end

        // All ports streaming single-word packets: strict rotation from port 0.
        do_reset();
        req_valid = '1;
        req_last  = '1;
        for (int p = 0; p < P; p++) req_data[p*W +: W] = W'(16'h1000 + p);
        got.delete();
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            @(negedge clk);
            for (int p = 0; p < P; p++) begin
                if (req_ready[p] && req_valid[p]) begin
                    got.push_back(p);
                    chk("rr_data", fifo_out_data, W'(16'h1000 + p));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rr_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk($sformatf("rr_src%0d", i), got[i], i % P);

        // MAX_BURST=4: port 1 sends 10 words, port 3 interleaves single-word packets.
        do_reset();
        n_words = '{0, 10, 0, 1000};
        pkt_len = '{0, 10, 0, 1};
        wcnt    = '{default: 0};
        run_seq(1'b1, 60);
        exp_a = '{104, 301, 104, 301, 102};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b4_burst%0d", i), (i < bursts.size()) ? bursts[i] : -1, exp_a[i]);
        end

        // Last word landing exactly on the MAX_BURST-th beat ends the burst only once.
        do_reset();
        n_words = '{0, 8, 0, 0};
        pkt_len = '{0, 4, 0, 0};
        wcnt    = '{default: 0};
        run_seq(1'b1, 30);
        chk("edge_nbursts", bursts.size(), 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("edge_burst%0d", i), (i < bursts.size()) ? bursts[i] : -1, 104);
        end

        // Reset asserted during word 4 of an 8-word packet from port 2.
        do_reset();
        n_words = '{0, 0, 8, 0};
        pkt_len = '{0, 0, 8, 0};
        wcnt    = '{default: 0};
        for (int c = 0; c < 20 && wcnt[2] < 3; c++) begin
            drive_ports('1);
            @(negedge clk);
            if (req_ready[2] && req_valid[2]) wcnt[2]++;
            @(posedge clk);
            #1;
        end
        drive_ports('1);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", fifo_out_valid, 1'b0);
        chk("mid_rst_data", fifo_out_data, '0);
        chk("mid_rst_grant", grant, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", req_ready, '0);
        chk("mid_rst_busy_b4", busy_b, 1'b0);
        n_words = '{6, 0, 8, 0};
        pkt_len = '{6, 0, 8, 0};
        wcnt    = '{default: 0};
        drive_ports('1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(1'b1, 60);
        chk("post_rst_first_grant", first_grant_main, 4'b0001);
        exp_c = '{4, 204, 2, 204};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_burst%0d", i), (i < bursts.size()) ? bursts[i] : -1,
                exp_c[i]);
        end

        // Randomized: three 200-word packets, random valid and fifo_out_ready.
        do_reset();
        n_words  = '{200, 200, 200, 0};
        pkt_len  = '{200, 200, 200, 0};
        wcnt     = '{default: 0};
        rx       = '{default: 0};
        m_owner  = -1;
        m_last   = P - 1;
        m_beats  = 0;
        m_hdr    = 1'b0;
        all_done = 1'b0;
        for (int c = 0; c < 30000 && !all_done; c++) begin
            fifo_out_ready = 1'($urandom_range(0, 1));
            for (int p = 0; p < P; p++) en_r[p] = ($urandom_range(0, 3) != 0);
            drive_ports(en_r);
            @(negedge clk);
            model_step();
            for (int p = 0; p < P; p++) if (req_valid[p] && req_ready[p]) wcnt[p]++;
            all_done = (rx[0] == 200) && (rx[1] == 200) && (rx[2] == 200);
            @(posedge clk);
            #1;
        end
        chk("rand_done", all_done, 1'b1);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("rand_rx%0d", p), rx[p], 200);
            chk($sformatf("rand_sent%0d", p), wcnt[p], 200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
